interpolator: RTL and testbench
===============================

INTERPOLATOR -- requirements
Module: interpolator

Interface
REQ-001 Parameter W, default 5: signed sample width in bits (W >= 2).
REQ-002 Parameter R, default 5: interpolation factor, i.e. output samples per input sample (R >= 1).
REQ-003 i_clk  input  1: sole clock; all logic on rising edge.
REQ-004 i_rst_n  input  1: reset, asynchronous assert, active-low.
REQ-005 i_data  input  W signed: input sample, qualified by i_ready.
REQ-006 i_ready  input  1: one-cycle strobe, i_data valid this cycle.
REQ-007 i_tick  input  1: output-rate strobe; at most one output sample per tick.
REQ-008 o_data  output  W signed: output sample, qualified by o_ready.
REQ-009 o_ready  output  1: one-cycle strobe, o_data valid this cycle.
REQ-010 o_full  output  1: input buffer holds 2 samples.
REQ-011 o_overflow  output  1: one-cycle pulse, input sample dropped.

Function
REQ-012 The block SHALL hold input samples in a 2-entry FIFO with write on i_ready and read on pop, preserving order.
REQ-013 When the FIFO is full and i_ready is high with no pop that cycle, the sample SHALL be dropped, the FIFO left unchanged, and o_overflow pulsed the next cycle.
REQ-014 When the FIFO is full and i_ready coincides with a pop, the write SHALL be accepted.
REQ-015 The FSM SHALL have two states, IDLE and EMIT, plus a phase counter of ceil(log2(R+1)) bits.
REQ-016 In IDLE, with i_tick high and the FIFO non-empty, the block SHALL pop the head, register it as the held sample, and drive o_data=sample with o_ready=1 the next cycle.
REQ-017 After that pop, the phase SHALL be set to 1 and the state SHALL go to EMIT if R>1, else remain IDLE.
REQ-018 In IDLE, with i_tick high and the FIFO empty (underrun), o_ready SHALL stay 0 and no state SHALL change.
REQ-019 In EMIT, each i_tick SHALL emit one sample with o_ready=1 the next cycle and increment the phase.
REQ-020 In EMIT, when the phase equals R-1 at the tick, the block SHALL emit the last sample, clear the phase, and return to IDLE.
REQ-021 Without i_tick, the state, phase and FIFO read side SHALL hold, and o_ready SHALL be 0.
REQ-022 A sample written in cycle n SHALL be poppable no earlier than cycle n+1; a write into an empty FIFO coincident with a tick SHALL not be popped that cycle.
REQ-023 Latency SHALL be one cycle from a qualifying i_tick to the o_ready strobe.
REQ-024 o_data SHALL hold its last value when o_ready is 0.
REQ-025 The block SHALL emit exactly R outputs per accepted input, in input order, with no arithmetic growth (output width W).

Reset
REQ-026 On i_rst_n low, the block SHALL immediately reset:
  - FIFO empty;
  - state IDLE, phase 0, held sample 0;
  - o_data=0, o_ready=0, o_full=0, o_overflow=0.
REQ-027 Reset mid-burst SHALL discard the remaining phases and buffered samples, with no outputs after release until a new input is accepted.
REQ-028 Reset release SHALL take effect at the first i_clk edge with i_rst_n high.

Configuration
REQ-029 Macro INTERPOLATOR_ZERO_STUFF_EN selects the non-first output phases.
REQ-030 With INTERPOLATOR_ZERO_STUFF_EN defined, phases 1..R-1 SHALL output 0 (zero-stuffing for a downstream CIC integrator chain).
REQ-031 With INTERPOLATOR_ZERO_STUFF_EN undefined, phases 1..R-1 SHALL output the held sample (zero-order hold).
REQ-032 Phase 0 SHALL always output the sample; all timing is identical in both builds.

Verification
REQ-033 R=5, hold build, i_tick constant 1, one input 7 -> o_ready for 5 consecutive cycles, o_data=7,7,7,7,7, then idle.
REQ-034 R=5, zero-stuff build, inputs 3 then -2 preloaded, i_tick=1 -> o_data=3,0,0,0,0,-2,0,0,0,0 back-to-back.
REQ-035 i_tick=0, three i_ready strobes (1,2,3) -> o_full=1 after two, o_overflow pulse after the third; later ticks output 1 then 2 only.
REQ-036 FIFO full, i_ready coincident with a pop tick -> no overflow; new sample output after the buffered one.
REQ-037 i_rst_n low at output phase 2 of 5 -> all outputs 0 asynchronously; after release with i_tick=1 and no input -> o_ready stays 0.
REQ-038 R=1, inputs 4,5,6 at one per cycle with i_tick=1 -> outputs 4,5,6, each once, with one-cycle latency after pop eligibility.

Source files
------------

// File: rtl/interpolator.sv
`default_nettype none
// ============================================================================
//  Module      : interpolator
//  Description : Sample-rate interpolator by R. Input samples are buffered
//                in a 2-entry FIFO; each accepted sample produces exactly R
//                output samples, one per i_tick. Phase 0 always carries the
//                sample itself.
//                Optional feature macro: INTERPOLATOR_ZERO_STUFF_EN
//                  defined   -> phases 1..R-1 output 0 (zero stuffing)
//                  undefined -> phases 1..R-1 repeat the sample (zero-order hold)
//  Revision    : 1.0 - initial release
// ============================================================================
module interpolator #(
   parameter int W = 5,
   parameter int R = 5
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic signed [W-1:0] i_data,
   input  logic                i_ready,
   input  logic                i_tick,
   output logic signed [W-1:0] o_data,
   output logic                o_ready,
   output logic                o_full,
   output logic                o_overflow
);

   localparam int             PW     = $clog2(R + 1);
   localparam logic [PW-1:0]  c_LAST = PW'(R - 1);

`ifdef INTERPOLATOR_ZERO_STUFF_EN
   localparam logic c_ZERO_STUFF = 1'b1;
`else
   localparam logic c_ZERO_STUFF = 1'b0;
`endif

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_EMIT = 1'b1
   } state_t;

   // FIFO storage and pointers
   logic signed [W-1:0] r_mem [2];
   logic                r_wptr;
   logic                r_rptr;
   logic [1:0]          r_count;

   // Output-side state
   state_t              r_state;
   logic [PW-1:0]       r_phase;
   logic signed [W-1:0] r_held;
   logic signed [W-1:0] r_odata;
   logic                r_ordy;
   logic                r_ovf;

   logic                w_empty;
   logic                w_full;
   logic                w_pop;
   logic                w_wr;
   logic                w_drop;
   logic signed [W-1:0] w_head;

   // Pop decisions look only at the registered count, so a sample written
   // this cycle can never be popped in the same cycle.
   assign w_empty = (r_count == 2'd0);
   assign w_full  = (r_count == 2'd2);
   assign w_pop   = i_tick & ~w_empty & (r_state == S_IDLE);
   assign w_wr    = i_ready & (~w_full | w_pop);
   assign w_drop  = i_ready & w_full & ~w_pop;
   assign w_head  = r_mem[r_rptr];

   assign o_data     = r_odata;
   assign o_ready    = r_ordy;
   assign o_full     = w_full;
   assign o_overflow = r_ovf;

   // FIFO: write on accepted i_ready, read on pop; a write into a full FIFO
   // is only accepted when the head leaves in the same cycle.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_mem[0] <= '0;
         r_mem[1] <= '0;
         r_wptr   <= 1'b0;
         r_rptr   <= 1'b0;
         r_count  <= 2'd0;
         r_ovf    <= 1'b0;
      end else begin
         r_ovf <= w_drop;
         if (w_wr) begin
            r_mem[r_wptr] <= i_data;
            r_wptr        <= ~r_wptr;
         end
         if (w_pop) begin
            r_rptr <= ~r_rptr;
         end
         case ({w_wr, w_pop})
            2'b10:   r_count <= r_count + 2'd1;
            2'b01:   r_count <= r_count - 2'd1;
            default: r_count <= r_count;
         endcase
      end
   end

   // Emission FSM: IDLE pops and emits phase 0, EMIT produces phases 1..R-1.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
         r_phase <= '0;
         r_held  <= '0;
         r_odata <= '0;
         r_ordy  <= 1'b0;
      end else begin
         r_ordy <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_pop) begin
                  r_held  <= w_head;
                  r_odata <= w_head;
                  r_ordy  <= 1'b1;
                  if (R > 1) begin
                     r_phase <= PW'(1);
                     r_state <= S_EMIT;
                  end
               end
            end
            S_EMIT: begin
               if (i_tick) begin
                  r_ordy  <= 1'b1;
                  r_odata <= c_ZERO_STUFF ? '0 : r_held;
                  if (r_phase == c_LAST) begin
                     r_phase <= '0;
                     r_state <= S_IDLE;
                  end else begin
                     r_phase <= r_phase + PW'(1);
                  end
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_phase <= '0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_interpolator.sv
`default_nettype none
// ============================================================================
//  Module      : tb_interpolator
//  Description : Scoreboard bench for interpolator. Two instances (R=5 and
//                R=1) share one input stream; a reference model predicts
//                every output sample and its cycle, a monitor checks them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_interpolator;

   localparam int W = 5;
`ifdef INTERPOLATOR_ZERO_STUFF_EN
   localparam bit ZS = 1'b1;
`else
   localparam bit ZS = 1'b0;
`endif

   logic                clk;
   logic                rst_n;
   logic signed [W-1:0] i_data;
   logic                i_ready;
   logic                i_tick;
   logic signed [W-1:0] od   [2];
   logic                ordy [2];
   logic                ofull[2];
   logic                oovf [2];

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   // Reference model state, per instance
   int rfac [2] = '{5, 1};
   int mfifo[2][2];
   int mcnt [2];
   int mrem [2];
   int mheld[2];
   int efull[2];
   int eovf [2];
   int mon_last[2];

   // Scoreboards: expected value and expected cycle
   int qd0[$], qc0[$], qd1[$], qc1[$];

   interpolator #(.W(W), .R(5)) u_dut5 (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_ready(i_ready),
      .i_tick(i_tick), .o_data(od[0]), .o_ready(ordy[0]),
      .o_full(ofull[0]), .o_overflow(oovf[0]));

   interpolator #(.W(W), .R(1)) u_dut1 (
      .i_clk(clk), .i_rst_n(rst_n), .i_data(i_data), .i_ready(i_ready),
      .i_tick(i_tick), .o_data(od[1]), .o_ready(ordy[1]),
      .o_full(ofull[1]), .o_overflow(oovf[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input int k, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s[R=%0d] @cyc %0d: got %0d, expected %0d", nm, rfac[k], cyc, act, exp);
      end
   endtask

   task automatic push(input int k, input int d, input int c);
      if (k == 0) begin qd0.push_back(d); qc0.push_back(c); end
      else        begin qd1.push_back(d); qc1.push_back(c); end
   endtask

   // One clock of behaviour: R outputs per accepted sample, FIFO of depth 2.
   task automatic model(input int k);
      bit popped = 0;
      if (i_tick) begin
         if (mrem[k] > 0) begin
            push(k, ZS ? 0 : mheld[k], cyc + 1);
            mrem[k]--;
         end else if (mcnt[k] > 0) begin
            mheld[k] = mfifo[k][0];
            mfifo[k][0] = mfifo[k][1];
            mcnt[k]--;
            push(k, mheld[k], cyc + 1);
            mrem[k] = rfac[k] - 1;
            popped = 1;
         end
      end
      eovf[k] = 0;
      if (i_ready) begin
         if (mcnt[k] < 2) begin
            mfifo[k][mcnt[k]] = int'($signed(i_data));
            mcnt[k]++;
         end else begin
            eovf[k] = 1;
         end
      end
      efull[k] = (mcnt[k] == 2) ? 1 : 0;
      if (popped) begin end
   endtask

   task automatic step(input logic rdy, input int d, input logic tk);
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
         chk("o_full", k, int'(ofull[k]), efull[k]);
         chk("o_overflow", k, int'(oovf[k]), eovf[k]);
      end
      i_ready = rdy;
      i_data  = W'(d);
      i_tick  = tk;
      for (int k = 0; k < 2; k++) model(k);
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      rst_n   = 1'b0;
      i_ready = 1'b0;
      i_tick  = 1'b0;
      i_data  = '0;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("rst_o_data", k, int'(od[k]), 0);
         chk("rst_o_ready", k, int'(ordy[k]), 0);
         chk("rst_o_full", k, int'(ofull[k]), 0);
         chk("rst_o_overflow", k, int'(oovf[k]), 0);
         mcnt[k] = 0; mrem[k] = 0; mheld[k] = 0;
         efull[k] = 0; eovf[k] = 0; mon_last[k] = 0;
      end
      qd0.delete(); qc0.delete(); qd1.delete(); qc1.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // Monitor: every o_ready strobe must match the scoreboard head, both in
   // value and in cycle; between strobes o_data must keep the last sample.
   always @(negedge clk) begin
      if (rst_n) begin
         for (int k = 0; k < 2; k++) begin
            if (ordy[k]) begin
               if ((k == 0 ? qd0.size() : qd1.size()) == 0) begin
                  chk("unexpected_output", k, 1, 0);
               end else begin
                  int ed, ec;
                  if (k == 0) begin ed = qd0.pop_front(); ec = qc0.pop_front(); end
                  else        begin ed = qd1.pop_front(); ec = qc1.pop_front(); end
                  chk("o_data", k, int'(od[k]), ed);
                  chk("out_cycle", k, cyc, ec);
                  mon_last[k] = ed;
               end
            end else begin
               chk("o_data_hold", k, int'(od[k]), mon_last[k]);
               if ((k == 0 ? qc0.size() : qc1.size()) > 0) begin
                  if ((k == 0 ? qc0[0] : qc1[0]) <= cyc)
                     chk("missing_output", k, 0, 1);
               end
            end
         end
      end
   end

   initial begin
      rst_n = 1'b1; i_ready = 1'b0; i_tick = 1'b0; i_data = '0;
      for (int k = 0; k < 2; k++) begin
         mcnt[k] = 0; mrem[k] = 0; mheld[k] = 0;
         efull[k] = 0; eovf[k] = 0; mon_last[k] = 0;
      end
      repeat (2) @(negedge clk);
      do_reset();

      // Single sample with continuous ticks
      step(1, 7, 1);
      repeat (8) step(0, 0, 1);

      // Two samples preloaded, then drained back-to-back
      step(1, 3, 0);
      step(1, -2, 0);
      repeat (12) step(0, 0, 1);

      // Three writes without ticks: third one overflows
      step(1, 1, 0);
      step(1, 2, 0);
      step(1, 3, 0);
      repeat (2) step(0, 0, 0);
      repeat (12) step(0, 0, 1);

      // Full FIFO with a write coinciding with a pop
      step(1, 4, 0);
      step(1, 5, 0);
      step(0, 0, 0);
      step(1, 6, 1);
      repeat (18) step(0, 0, 1);

      // One sample per cycle with continuous ticks
      step(1, 4, 1);
      step(1, 5, 1);
      step(1, 6, 1);
      repeat (18) step(0, 0, 1);

      // Randomized traffic
      repeat (400) begin
         step(($urandom_range(0, 99) < 30), int'($urandom_range(0, 31)) - 16,
              ($urandom_range(0, 99) < 70));
      end
      repeat (20) step(0, 0, 1);

      // Reset in the middle of a burst
      step(1, 9, 0);
      step(1, 10, 0);
      step(0, 0, 1);
      step(0, 0, 1);
      step(0, 0, 1);
      do_reset();
      repeat (12) step(0, 0, 1);

      @(negedge clk);
      chk("leftover", 0, qd0.size(), 0);
      chk("leftover", 1, qd1.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
`default_nettype wire
